clk_phase_sched: RTL and testbench
==================================

# clk_phase_sched

Select-word scheduler for the 8-phase clock-randomizer mux tree (seven BUFGMUX_CTRL stages fed by the clock wizard's 0/45/…/315° outputs). It generates a new pseudo-random 7-bit phase select at a randomized dwell interval. After each change it holds the select stable for a fixed settle window, so every BUFGMUX_CTRL completes its glitch-free switch before the next one. It parks the tree on the undelayed input clock whenever the clock wizard is unlocked. It runs on `clk_in` and replaces the free-running LFSR that previously drove the mux selects.

## Interface

Parameters:
- `LFSR_SEED`, default 16'hACE1: reset value of the LFSR. A value of 0 is replaced by 16'hACE1.
- `DWELL_W`, default 8: width of the dwell count.
- `SETTLE_CYC`, default 4: number of hold cycles after a switch; must be ≥ 1.
- `CNT_W`, default 16: width of the switch counter.

Ports:
- `clk_in`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: enables randomized switching.
- `locked`, input, 1: clock-wizard lock, synchronous to `clk_in`.
- `dwell_min`, input, DWELL_W: minimum dwell, in cycles.
- `dwell_mask`, input, DWELL_W: mask applied to the random dwell extension.
- `sel_out`, output, 7: mux select; bit i drives MUX_i.
- `sel_upd`, output, 1: one-cycle pulse, high in the cycle where `sel_out` takes a new value.
- `busy`, output, 1: high in every state except IDLE.
- `switch_cnt`, output, CNT_W: count of completed switches; wraps to 0.

## Operation

- Reset values: `sel_out` = 0 (selects `clk_in` through MUX_0/2/6), `sel_upd` = 0, `busy` = 0, `switch_cnt` = 0, LFSR = seed, state = IDLE.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifted right.
  - Advances every cycle, independent of `en` and state, so it never reaches the all-zero state.
- Dwell load value: `D` = `dwell_min` + (`lfsr[15:8]` truncated/zero-extended to DWELL_W & `dwell_mask`).
  - Computed at DWELL_W+1 bits.
  - Saturates to 2^DWELL_W−1 on overflow.
- FSM states: IDLE, DWELL, SWITCH, SETTLE.
  - **IDLE**: `sel_out` held.
    - If `en`&&`locked`: go to DWELL, dwell counter ← D.
  - **DWELL**:
    - If `!locked` or `!en`: go to IDLE immediately.
    - Else if the counter is 0: go to SWITCH.
    - Else: decrement. DWELL therefore lasts D+1 cycles.
  - **SWITCH** (1 cycle): at the exit edge:
    - `sel_out` ← `lfsr[6:0]`. If this equals the current `sel_out`, use `lfsr[6:0]`^7'h01 instead, so the phase always changes.
    - `sel_upd` ← 1.
    - `switch_cnt` ← `switch_cnt`+1.
    - Settle counter ← SETTLE_CYC−1.
    - Go to SETTLE.
  - **SETTLE**: `sel_out` frozen; `en` is ignored.
    - When the counter is 0: go to DWELL (reload D) if `en`&&`locked`, else go to IDLE.
    - Else: decrement.
- Lock loss:
  - `locked`=0 in any state forces IDLE at the next edge and sets `sel_out` ← 7'h00.
  - `switch_cnt` is held.
  - This lock rule overrides the SETTLE freeze.
- `sel_upd` is 0 in every cycle except the one following SWITCH.
- `en` falling during SETTLE takes effect only when SETTLE ends.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- `en` rising while in IDLE (with `locked`=1) is sampled at edge 0.
  - DWELL occupies cycles 1..D+1.
  - SWITCH occupies cycle D+2.
  - The new `sel_out` and `sel_upd`=1 appear in cycle D+3.
- In steady state, consecutive `sel_upd` pulses are SETTLE_CYC+D+2 cycles apart, with D redrawn for each interval.
- Minimum spacing, at D=0 and SETTLE_CYC=1, is 3 cycles.
- `sel_out` is stable for at least SETTLE_CYC+1 cycles after each change.
- `locked` deassert: `sel_out` = 0 and `busy` = 0 one cycle later.
- `switch_cnt` increments in the same cycle `sel_upd` is high. It rolls over from 2^CNT_W−1 to 0.

## Test plan

- **Reset with `en`=0**: release `rst_n`, run 100 cycles. Require `sel_out`=0, `sel_upd`=0, `busy`=0, `switch_cnt`=0 throughout.
- **Fixed dwell**: set `dwell_min`=4, `dwell_mask`=0, SETTLE_CYC=4, `locked`=1, `en`=1. Require:
  - First `sel_upd` 7 cycles after `en` is sampled.
  - Subsequent pulses every 10 cycles.
  - `sel_out` changes on every pulse.
  - `switch_cnt` counts 1, 2, 3, …
- **Random dwell**: set `dwell_min`=250, `dwell_mask`=8'hFF. Require D to saturate at 255 (pulse spacing ≤ 261) and the spacing to vary between pulses, matching a reference LFSR model.
- **Lock loss during SETTLE**: drop `locked` 1 cycle after a `sel_upd`. Require `sel_out`=0 and `busy`=0 on the next cycle. Re-assert `locked` with `en`=1: require DWELL to restart and the next pulse D+3 cycles later.
- **`en` timing**: drop `en` mid-DWELL and require IDLE with no further pulse. Drop `en` mid-SETTLE and require SETTLE to finish, then IDLE, with `sel_out` retaining its last value.
- **Counter wrap and equal-draw**: with CNT_W=4, run 17 switches and require `switch_cnt` to wrap to 1. Force an LFSR draw equal to the current `sel_out` and require the new `sel_out` = draw^7'h01.

Source files
------------

// File: rtl/clk_phase_sched.sv
// clk_phase_sched: select-word scheduler for the 8-phase clock-randomizer mux tree.
//
// A free-running 16-bit Galois LFSR supplies both the next 7-bit phase select and a random dwell
// extension. Once enabled and locked, the block waits a randomized dwell interval and then switches
// `sel_out` to a new value. It then freezes `sel_out` for SETTLE_CYC cycles so that every
// BUFGMUX_CTRL stage can finish its glitch-free switch. Losing the clock-wizard lock parks the tree
// on the undelayed input clock (sel_out = 0) at the next edge.
//
// Ports:
//   clk_in      sole clock
//   rst_n       asynchronous active-low reset
//   en          enables randomized switching
//   locked      clock-wizard lock, synchronous to clk_in
//   dwell_min   minimum dwell, in cycles
//   dwell_mask  mask applied to the random dwell extension
//   sel_out     mux select, bit i drives MUX_i
//   sel_upd     one-cycle pulse in the cycle where sel_out takes a new value
//   busy        high whenever the scheduler is not idle
//   switch_cnt  count of completed switches, wraps to 0
module clk_phase_sched #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               locked,
  input  logic [DWELL_W-1:0] dwell_min,
  input  logic [DWELL_W-1:0] dwell_mask,
  output logic [6:0]         sel_out,
  output logic               sel_upd,
  output logic               busy,
  output logic [CNT_W-1:0]   switch_cnt
);

  // An all-zero seed would lock the LFSR up, so fall back to the default.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] Poly    = 16'hB400;
  localparam int unsigned SetW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDwell, StSwitch, StSettle} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SetW-1:0]    settle_q, settle_d;
  logic [6:0]         sel_q, sel_d;
  logic               upd_q, upd_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DWELL_W-1:0] rnd_ext;
  logic [DWELL_W:0]   dwell_sum;
  logic [DWELL_W-1:0] dwell_load;
  logic [6:0]         draw;
  logic [6:0]         new_sel;

  always_comb begin
    // LFSR runs every cycle regardless of state so it never stalls in any pattern.
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Poly : 16'h0000);

    // Dwell reload value, saturating instead of wrapping on overflow.
    rnd_ext    = DWELL_W'(lfsr_q[15:8]);
    dwell_sum  = {1'b0, dwell_min} + {1'b0, rnd_ext & dwell_mask};
    dwell_load = dwell_sum[DWELL_W] ? '1 : dwell_sum[DWELL_W-1:0];

    // Force an actual phase change when the draw repeats the current select.
    draw    = lfsr_q[6:0];
    new_sel = (draw == sel_q) ? (draw ^ 7'h01) : draw;
  end

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    upd_d    = 1'b0;
    cnt_d    = cnt_q;

    if (!locked) begin
      // Lock loss wins over everything, including the settle freeze.
      state_d = StIdle;
      sel_d   = 7'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            state_d = StDwell;
            dwell_d = dwell_load;
          end
        end
        StDwell: begin
          if (!en) begin
            state_d = StIdle;
          end else if (dwell_q == '0) begin
            state_d = StSwitch;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        StSwitch: begin
          sel_d    = new_sel;
          upd_d    = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          settle_d = SettleLoad;
          state_d  = StSettle;
        end
        StSettle: begin
          // en is only looked at once the settle window has fully elapsed.
          if (settle_q == '0) begin
            if (en) begin
              state_d = StDwell;
              dwell_d = dwell_load;
            end else begin
              state_d = StIdle;
            end
          end else begin
            settle_d = settle_q - SetW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_q   <= SeedEff;
      dwell_q  <= '0;
      settle_q <= '0;
      sel_q    <= 7'h00;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      dwell_q  <= dwell_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sel_out    = sel_q;
  assign sel_upd    = upd_q;
  assign busy       = busy_q;
  assign switch_cnt = cnt_q;

endmodule

// File: tb/tb_clk_phase_sched.sv
// tb_clk_phase_sched: directed bench for clk_phase_sched with an event-time reference model.
//
// The model tracks the scheduler as absolute edge times (when the next switch lands, when the
// settle window ends) plus the LFSR sequence, and a compare process checks every output on every
// falling edge. Directed phases add literal timing/value expectations.
module tb_clk_phase_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned CW = 4;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          locked = 1'b0;
  logic [DW-1:0] dwell_min  = '0;
  logic [DW-1:0] dwell_mask = '0;
  logic [6:0]    sel_out;
  logic          sel_upd;
  logic          busy;
  logic [CW-1:0] switch_cnt;

  clk_phase_sched #(
    .LFSR_SEED (16'hACE1),
    .DWELL_W   (DW),
    .SETTLE_CYC(SC),
    .CNT_W     (CW)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .locked    (locked),
    .dwell_min (dwell_min),
    .dwell_mask(dwell_mask),
    .sel_out   (sel_out),
    .sel_upd   (sel_upd),
    .busy      (busy),
    .switch_cnt(switch_cnt)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int calc_d(input logic [7:0] mn, input logic [7:0] mk, input logic [15:0] l);
    int s;
    s = int'(mn) + int'(l[15:8] & mk);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (edge-time based) ----------------
  logic [15:0]   m_lfsr;
  logic [6:0]    m_sel;
  logic          m_upd;
  logic          m_busy;
  logic [CW-1:0] m_cnt;
  bit            m_active;
  int            m_k, t_sw, t_end;

  initial begin
    m_lfsr = 16'hACE1; m_sel = '0; m_upd = 0; m_busy = 0; m_cnt = '0;
    m_active = 0; m_k = 0; t_sw = 0; t_end = 0;
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        m_lfsr = 16'hACE1; m_sel = '0; m_upd = 0; m_busy = 0; m_cnt = '0;
        m_active = 0; m_k = 0; t_sw = 0; t_end = 0;
      end else begin
        m_upd = 0;
        if (!locked) begin
          m_active = 0;
          m_sel    = '0;
        end else if (!m_active) begin
          if (en) begin
            m_active = 1;
            t_sw     = m_k + calc_d(dwell_min, dwell_mask, m_lfsr) + 2;
          end
        end else if (m_k < t_sw) begin
          if (!en) m_active = 0;
        end else if (m_k == t_sw) begin
          m_sel = (m_lfsr[6:0] == m_sel) ? (m_lfsr[6:0] ^ 7'h01) : m_lfsr[6:0];
          m_upd = 1;
          m_cnt = m_cnt + 1'b1;
          t_end = m_k + SC;
        end else if (m_k == t_end) begin
          if (en) t_sw = m_k + calc_d(dwell_min, dwell_mask, m_lfsr) + 2;
          else    m_active = 0;
        end
        m_busy = m_active;
        m_lfsr = lfsr_step(m_lfsr);
        m_k++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk_in);
      n_vec++;
      if (sel_out !== m_sel || sel_upd !== m_upd || busy !== m_busy || switch_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL cyc %0d: sel_out=%h sel_upd=%b busy=%b switch_cnt=%0d, expected %h %b %b %0d",
                 cyc, sel_out, sel_upd, busy, switch_cnt, m_sel, m_upd, m_busy, m_cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic wait_pulse(input int budget, output int t);
    bit seen;
    seen = 0;
    t    = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (sel_upd === 1'b1) begin
        seen = 1;
        t    = cyc;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL pulse_timeout: no sel_upd within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t, tp, sp, npulse;
    logic [6:0]    prev, saved;
    logic [CW-1:0] cnt_saved;
    logic [15:0]   ahead;
    bit            found;

    // Pin the model's arithmetic with hand-computed values.
    chk("lfsr_step1", 32'(lfsr_step(16'hACE1)), 32'hE270);
    chk("lfsr_step2", 32'(lfsr_step(16'hE270)), 32'h7138);
    chk("d_plain",    32'(calc_d(8'd4, 8'h00, 16'hFFFF)), 32'd4);
    chk("d_mask",     32'(calc_d(8'd3, 8'h0F, 16'hAB00)), 32'd14);
    chk("d_sat",      32'(calc_d(8'd250, 8'hFF, 16'h1000)), 32'd255);

    // Reset, then idle with en=0.
    locked = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(100);
    chk("rst_sel",  32'(sel_out), 32'h0);
    chk("rst_upd",  32'(sel_upd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt",  32'(switch_cnt), 32'h0);

    // Fixed dwell D=4: first pulse 7 cycles after en, then every 10.
    dwell_min  = 8'd4;
    dwell_mask = 8'h00;
    en         = 1'b1;
    t0         = cyc;
    prev       = sel_out;
    wait_pulse(50, t);
    chk("first_pulse_lat", 32'(t - t0), 32'd7);
    chk("cnt_1", 32'(switch_cnt), 32'd1);
    chk("sel_changed_1", 32'(sel_out != prev), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tp   = t;
      prev = sel_out;
      wait_pulse(50, t);
      chk("fixed_spacing", 32'(t - tp), 32'd10);
      chk("cnt_seq", 32'(switch_cnt), 32'(i));
      chk("sel_changed", 32'(sel_out != prev), 32'd1);
    end

    // Random dwell near saturation: spacing = SC + D + 2 with D in [250, 255].
    dwell_min  = 8'd250;
    dwell_mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tp = t;
      wait_pulse(400, t);
      sp = t - tp;
      chk("rnd_spacing_max", 32'(sp <= 261), 32'd1);
      chk("rnd_spacing_min", 32'(sp >= 256), 32'd1);
    end

    // Lock loss one cycle after a pulse, then recovery.
    dwell_min  = 8'd4;
    dwell_mask = 8'h00;
    wait_pulse(400, t);
    cnt_saved = switch_cnt;
    tick(1);
    locked = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("lockloss_sel",  32'(sel_out), 32'h0);
    chk("lockloss_busy", 32'(busy), 32'h0);
    chk("lockloss_cnt",  32'(switch_cnt), 32'(cnt_saved));
    tick(1);
    locked = 1'b1;
    t0     = cyc;
    wait_pulse(50, t);
    chk("relock_lat", 32'(t - t0), 32'd7);

    // en dropped mid-DWELL: back to IDLE, no further pulse.
    dwell_min = 8'd20;
    tick(10);
    en    = 1'b0;
    saved = sel_out;
    npulse = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (sel_upd === 1'b1) npulse++;
    end
    chk("dwell_en_drop_pulses", 32'(npulse), 32'd0);
    chk("dwell_en_drop_busy", 32'(busy), 32'd0);
    chk("dwell_en_drop_sel", 32'(sel_out), 32'(saved));

    // en dropped mid-SETTLE: settle completes, then IDLE with sel_out kept.
    dwell_min = 8'd4;
    tick(1);
    en = 1'b1;
    wait_pulse(50, t);
    saved = sel_out;
    tick(1);
    en = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("settle_busy_hold", 32'(busy), 32'd1);
    @(negedge clk_in);
    chk("settle_busy_end", 32'(busy), 32'd0);
    chk("settle_sel_kept", 32'(sel_out), 32'(saved));
    repeat (20) @(negedge clk_in);
    chk("idle_sel_kept", 32'(sel_out), 32'(saved));

    // Counter wrap: 17 switches from reset with a 4-bit counter.
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n      = 1'b1;
    dwell_min  = 8'd0;
    dwell_mask = 8'h00;
    en         = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      wait_pulse(50, t);
      chk("cnt_wrap", 32'(switch_cnt), 32'(i % 16));
    end

    // Equal draw: park at sel_out=0, then time en so the switching draw is 0.
    tick(1);
    en     = 1'b0;
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(2);
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      ahead = lfsr_step(lfsr_step(m_lfsr));
      if (ahead[6:0] == 7'h00) begin
        found = 1;
        en    = 1'b1;
      end else begin
        tick(1);
      end
    end
    chk("equal_draw_found", 32'(found), 32'd1);
    if (found) begin
      wait_pulse(20, t);
      chk("equal_draw_sel", 32'(sel_out), 32'h01);
    end
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
